// File: rtl/fft_frame_burst_tx.sv
// fft_frame_burst_tx
// Frame re-emitter placed between FFT stages. Rows of 16 complex lanes arrive at
// any rate (gaps allowed, no backpressure). Each sample is requantized from IN_W to
// OUT_W bits (optional rounding right-shift, then saturation) and the row is written
// into a two-bank ping-pong buffer of DEPTH rows per bank. Every completed bank is
// replayed as one contiguous DEPTH-cycle valid burst, followed by at least one idle
// cycle so the downstream valid counter can rearm.
//
// Ports
//   clk         rising-edge clock
//   rstn        asynchronous active-low reset; discards all buffered frames
//   din_re/im   input row, 16 lanes of IN_W-bit signed samples
//   din_valid   input row valid this cycle
//   dout_re/im  output row, 16 lanes of OUT_W-bit signed samples (0 when not valid)
//   dout_valid  high for exactly DEPTH consecutive cycles per frame
//   frame_done  one-cycle pulse coincident with the last row of a burst
//   ovf_err     sticky: a row arrived while both banks were full (row dropped)
//   sat_err     sticky: at least one written sample was clipped
module fft_frame_burst_tx #(
  parameter int IN_W  = 13,
  parameter int OUT_W = 12,
  parameter int SHIFT = 0,
  parameter int DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [15:0][IN_W-1:0]  din_re,
  input  logic [15:0][IN_W-1:0]  din_im,
  input  logic                   din_valid,
  output logic [15:0][OUT_W-1:0] dout_re,
  output logic [15:0][OUT_W-1:0] dout_im,
  output logic                   dout_valid,
  output logic                   frame_done,
  output logic                   ovf_err,
  output logic                   sat_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ROW = AW'(DEPTH - 1);

  // Rounding constant and saturation bounds, all held in IN_W+1 bits so the
  // rounding add can never wrap.
  localparam int RND_I = (SHIFT > 0) ? (2 ** ((SHIFT > 0) ? (SHIFT - 1) : 0)) : 0;
  localparam logic signed [IN_W:0] RND     = (IN_W + 1)'(RND_I);
  localparam logic signed [IN_W:0] SAT_MAX = (IN_W + 1)'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [IN_W:0] SAT_MIN = (IN_W + 1)'(-(2 ** (OUT_W - 1)));

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Returns {clipped, value}: round-shift then saturate one sample.
  function automatic logic [OUT_W:0] requant(input logic [IN_W-1:0] x);
    logic signed [IN_W:0] w_ext;
    logic signed [IN_W:0] w_t;
    logic [OUT_W:0]       w_res;
    w_ext = $signed({x[IN_W-1], x});
    w_t   = (w_ext + RND) >>> SHIFT;
    if (w_t > SAT_MAX) begin
      w_res = {1'b1, SAT_MAX[OUT_W-1:0]};
    end else if (w_t < SAT_MIN) begin
      w_res = {1'b1, SAT_MIN[OUT_W-1:0]};
    end else begin
      w_res = {1'b0, w_t[OUT_W-1:0]};
    end
    return w_res;
  endfunction

  // Buffer storage: address = {bank, row}
  logic [15:0][OUT_W-1:0] r_mem_re [0:2*DEPTH-1];
  logic [15:0][OUT_W-1:0] r_mem_im [0:2*DEPTH-1];

  logic [1:0]    r_full;
  logic          r_wr_bank;
  logic [AW-1:0] r_wr_row;
  logic          r_rd_bank;
  logic [AW-1:0] r_rd_row;
  state_t        r_state;
  logic          r_ovf;
  logic          r_sat;

  logic [15:0][OUT_W-1:0] r_dout_re;
  logic [15:0][OUT_W-1:0] r_dout_im;
  logic                   r_dout_valid;
  logic                   r_frame_done;

  logic [15:0][OUT_W-1:0] w_q_re;
  logic [15:0][OUT_W-1:0] w_q_im;
  logic                   w_clip;
  logic                   w_wr_en;
  logic                   w_drop;
  logic                   w_wr_last;
  logic                   w_emit;
  logic                   w_rd_last;
  logic [1:0]             w_full_nxt;
  state_t                 w_state_nxt;

  // Requantize all 32 samples of the incoming row and collect any clip.
  always_comb begin
    logic [OUT_W:0] w_r;
    logic [OUT_W:0] w_i;
    w_q_re = '0;
    w_q_im = '0;
    w_clip = 1'b0;
    for (int i = 0; i < 16; i++) begin
      w_r       = requant(din_re[i]);
      w_i       = requant(din_im[i]);
      w_q_re[i] = w_r[OUT_W-1:0];
      w_q_im[i] = w_i[OUT_W-1:0];
      w_clip    = w_clip | w_r[OUT_W] | w_i[OUT_W];
    end
  end

  // Write qualification; full is sampled before the edge, so a write into the bank
  // being released on this same edge is still treated as overflow.
  always_comb begin
    w_wr_en   = din_valid & ~r_full[r_wr_bank];
    w_drop    = din_valid &  r_full[r_wr_bank];
    w_wr_last = w_wr_en & (r_wr_row == LAST_ROW);
  end

  // Read FSM next state; the IDLE cycle that finds a full bank already emits row 0.
  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_full[r_rd_bank]) begin
          w_emit      = 1'b1;
          w_state_nxt = ST_BURST;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BURST: begin
        w_emit = 1'b1;
        if (r_rd_row == LAST_ROW) begin
          w_state_nxt = ST_GAP;
        end else begin
          w_state_nxt = ST_BURST;
        end
      end
      ST_GAP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_rd_last = w_emit & (r_rd_row == LAST_ROW);
  end

  // Bank-full flags: set by the last write, cleared by the last read. The two can
  // never target the same bank on one edge (set needs it empty, clear needs it full).
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_full_nxt[b] = (r_full[b] | (w_wr_last & (r_wr_bank == b[0])))
                      & ~(w_rd_last & (r_rd_bank == b[0]));
    end
  end

  // Buffer write port (contents need no reset; the full flags gate every read).
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem_re[{r_wr_bank, r_wr_row}] <= w_q_re;
      r_mem_im[{r_wr_bank, r_wr_row}] <= w_q_im;
    end
  end

  // Write-side pointers, full flags and sticky error flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_full    <= 2'b00;
      r_wr_bank <= 1'b0;
      r_wr_row  <= '0;
      r_ovf     <= 1'b0;
      r_sat     <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      if (w_wr_en) begin
        r_wr_row <= w_wr_last ? '0 : (r_wr_row + AW'(1));
        if (w_wr_last) begin
          r_wr_bank <= ~r_wr_bank;
        end
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
      if (w_wr_en & w_clip) begin
        r_sat <= 1'b1;
      end
    end
  end

  // Read-side state, pointers and registered output row.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_rd_bank    <= 1'b0;
      r_rd_row     <= '0;
      r_dout_re    <= '0;
      r_dout_im    <= '0;
      r_dout_valid <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_emit) begin
        r_dout_re    <= r_mem_re[{r_rd_bank, r_rd_row}];
        r_dout_im    <= r_mem_im[{r_rd_bank, r_rd_row}];
        r_dout_valid <= 1'b1;
        r_frame_done <= w_rd_last;
        r_rd_row     <= w_rd_last ? '0 : (r_rd_row + AW'(1));
        if (w_rd_last) begin
          r_rd_bank <= ~r_rd_bank;
        end
      end else begin
        r_dout_re    <= '0;
        r_dout_im    <= '0;
        r_dout_valid <= 1'b0;
        r_frame_done <= 1'b0;
      end
    end
  end

  assign dout_re    = r_dout_re;
  assign dout_im    = r_dout_im;
  assign dout_valid = r_dout_valid;
  assign frame_done = r_frame_done;
  assign ovf_err    = r_ovf;
  assign sat_err    = r_sat;

endmodule

// File: tb/tb_fft_frame_burst_tx.sv
// Testbench for fft_frame_burst_tx. Two instances share the stimulus: one with
// SHIFT=0 and one with SHIFT=1. A schedule model (frame ready times, burst windows,
// bank occupancy counted as undrained complete frames) predicts every output cycle;
// literal checks pin the model to hand-computed values.
module tb_fft_frame_burst_tx;
  localparam int D    = 32;
  localparam int L    = 16;
  localparam int MAXF = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic [15:0][12:0] din_re;
  logic [15:0][12:0] din_im;
  logic              din_valid;

  logic [15:0][11:0] a_re, a_im, b_re, b_im;
  logic a_v, a_fd, a_ovf, a_sat;
  logic b_v, b_fd, b_ovf, b_sat;

  always #5 clk = ~clk;

  fft_frame_burst_tx #(.IN_W(13), .OUT_W(12), .SHIFT(0), .DEPTH(D)) u_s0 (
    .clk(clk), .rstn(rstn), .din_re(din_re), .din_im(din_im), .din_valid(din_valid),
    .dout_re(a_re), .dout_im(a_im), .dout_valid(a_v), .frame_done(a_fd),
    .ovf_err(a_ovf), .sat_err(a_sat));

  fft_frame_burst_tx #(.IN_W(13), .OUT_W(12), .SHIFT(1), .DEPTH(D)) u_s1 (
    .clk(clk), .rstn(rstn), .din_re(din_re), .din_im(din_im), .din_valid(din_valid),
    .dout_re(b_re), .dout_im(b_im), .dout_valid(b_v), .frame_done(b_fd),
    .ovf_err(b_ovf), .sat_err(b_sat));

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- model state ----------------
  int m_e;                      // edges since reset release
  int m_nf;                     // complete frames
  int m_wr;                     // rows in the frame being filled
  int m_start [MAXF];
  int m_end   [MAXF];
  int raw_re  [MAXF*D][L];
  int raw_im  [MAXF*D][L];
  bit m_ovf;
  bit m_sat [2];

  function automatic int quant(int x, int sh);
    int t;
    t = (sh > 0) ? ((x + (1 << (sh - 1))) >>> sh) : x;
    if (t > 2047) t = 2047;
    if (t < -2048) t = -2048;
    return t;
  endfunction

  function automatic bit clips(int x, int sh);
    int t;
    t = (sh > 0) ? ((x + (1 << (sh - 1))) >>> sh) : x;
    return (t > 2047) || (t < -2048);
  endfunction

  function automatic int sv12(logic [11:0] x);
    return int'($signed(x));
  endfunction

  // Model update at every rising edge.
  initial begin
    m_e = 0; m_nf = 0; m_wr = 0; m_ovf = 1'b0; m_sat[0] = 1'b0; m_sat[1] = 1'b0;
    forever begin
      @(posedge clk);
      if (!rstn) begin
        m_e = 0; m_nf = 0; m_wr = 0; m_ovf = 1'b0; m_sat[0] = 1'b0; m_sat[1] = 1'b0;
      end else begin
        m_e++;
        if (din_valid) begin
          int nfull;
          nfull = 0;
          for (int n = 0; n < m_nf; n++) if (m_end[n] >= m_e) nfull++;
          if (nfull >= 2) begin
            m_ovf = 1'b1;
          end else begin
            if (m_nf >= MAXF) begin
              $display("FAIL model_capacity: frames %0d exceed %0d", m_nf, MAXF);
              $fatal(1);
            end
            for (int i = 0; i < L; i++) begin
              raw_re[m_nf*D + m_wr][i] = int'($signed(din_re[i]));
              raw_im[m_nf*D + m_wr][i] = int'($signed(din_im[i]));
              for (int s = 0; s < 2; s++) begin
                if (clips(raw_re[m_nf*D + m_wr][i], s) || clips(raw_im[m_nf*D + m_wr][i], s))
                  m_sat[s] = 1'b1;
              end
            end
            m_wr++;
            if (m_wr == D) begin
              m_start[m_nf] = m_e + 1;
              if (m_nf > 0 && m_end[m_nf-1] + 2 > m_start[m_nf]) m_start[m_nf] = m_end[m_nf-1] + 2;
              m_end[m_nf] = m_start[m_nf] + D - 1;
              m_nf++;
              m_wr = 0;
            end
          end
        end
      end
    end
  end

  task automatic check_dut(input string nm, input int sh,
                           input logic [15:0][11:0] re, input logic [15:0][11:0] im,
                           input logic v, input logic fd, input logic ovf, input logic sat);
    bit ev, efd, eovf, esat, ok;
    int idx, bad_lane, ere, eim;
    ev = 1'b0; efd = 1'b0; idx = 0; bad_lane = -1;
    eovf = rstn ? m_ovf : 1'b0;
    esat = rstn ? m_sat[sh] : 1'b0;
    if (rstn) begin
      for (int n = 0; n < m_nf; n++) begin
        if (m_start[n] <= m_e && m_e <= m_end[n]) begin
          ev = 1'b1; efd = (m_e == m_end[n]); idx = n*D + (m_e - m_start[n]);
        end
      end
    end
    ok = (v == ev) && (fd == efd) && (ovf == eovf) && (sat == esat);
    for (int i = 0; i < L; i++) begin
      ere = ev ? quant(raw_re[idx][i], sh) : 0;
      eim = ev ? quant(raw_im[idx][i], sh) : 0;
      if (sv12(re[i]) != ere || sv12(im[i]) != eim) begin
        ok = 1'b0;
        if (bad_lane < 0) bad_lane = i;
      end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL cycle_%s e=%0d: valid %0d/%0d done %0d/%0d ovf %0d/%0d sat %0d/%0d lane %0d re %0d/%0d (got/expected)",
               nm, m_e, v, ev, fd, efd, ovf, eovf, sat, esat, bad_lane,
               (bad_lane >= 0) ? sv12(re[bad_lane]) : 0,
               (bad_lane >= 0) ? (ev ? quant(raw_re[idx][bad_lane], sh) : 0) : 0);
    end
  endtask

  // Compare both instances against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      check_dut("s0", 0, a_re, a_im, a_v, a_fd, a_ovf, a_sat);
      check_dut("s1", 1, b_re, b_im, b_v, b_fd, b_ovf, b_sat);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic send_row(input int re[L], input int im[L]);
    for (int i = 0; i < L; i++) begin
      din_re[i] = 13'(re[i]);
      din_im[i] = 13'(im[i]);
    end
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic send_seq(input int r);
    int re[L];
    int im[L];
    for (int i = 0; i < L; i++) begin
      re[i] = r*16 + i;
      im[i] = -(r*16 + i);
    end
    send_row(re, im);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rstn = 1'b0;
    idle(3);
    rstn = 1'b1;
  endtask

  initial begin
    int re[L];
    int im[L];
    din_valid = 1'b0;
    din_re = '0;
    din_im = '0;

    // Reset state
    idle(2);
    chk("reset_valid", a_v, 0);
    chk("reset_dout", sv12(a_re[0]), 0);
    chk("reset_flags", {a_fd, a_ovf, a_sat}, 0);
    idle(1);
    rstn = 1'b1;

    // 1: one frame, latency and burst shape
    for (int r = 0; r < D; r++) send_seq(r);
    chk("t1_idle_at_last_write", a_v, 0);
    idle(1);
    chk("t1_first_valid", a_v, 1);
    chk("t1_row0_re5", sv12(a_re[5]), 5);
    chk("t1_row0_im5", sv12(a_im[5]), -5);
    idle(31);
    chk("t1_done_last", a_fd, 1);
    chk("t1_row31_re0", sv12(a_re[0]), 496);
    idle(1);
    chk("t1_gap_valid", a_v, 0);
    chk("t1_gap_dout", sv12(a_re[0]), 0);
    idle(3);

    // 2 and 3: requantization and saturation
    do_reset();
    for (int i = 0; i < L; i++) begin re[i] = 0; im[i] = 0; end
    re[0] = 2100; re[1] = -2100; re[2] = 1000; re[3] = -2048;
    send_row(re, im);
    chk("t2_sat_s0_row0", a_sat, 1);
    chk("t3_nosat_s1_row0", b_sat, 0);
    re[0] = 7; re[1] = -7; re[2] = 4095; re[3] = -4096;
    send_row(re, im);
    chk("t3_sat_s1_row1", b_sat, 1);
    for (int r = 2; r < D; r++) send_seq(r);
    idle(1);
    chk("t2_s0_l0", sv12(a_re[0]), 2047);
    chk("t2_s0_l1", sv12(a_re[1]), -2048);
    chk("t2_s0_l2", sv12(a_re[2]), 1000);
    chk("t2_s0_l3", sv12(a_re[3]), -2048);
    idle(1);
    chk("t3_s1_l0", sv12(b_re[0]), 4);
    chk("t3_s1_l1", sv12(b_re[1]), -3);
    chk("t3_s1_l2", sv12(b_re[2]), 2047);
    chk("t3_s1_l3", sv12(b_re[3]), -2048);
    idle(35);

    // 4: three back-to-back frames
    do_reset();
    for (int r = 0; r < 3*D; r++) begin
      send_seq(r);
      if (r + 1 == 64) chk("t4_done1", a_fd, 1);
      if (r + 1 == 65) chk("t4_gap1", a_v, 0);
      if (r + 1 == 66) begin
        chk("t4_burst2_valid", a_v, 1);
        chk("t4_burst2_row0", sv12(a_re[0]), 512);
      end
    end
    idle(40);
    chk("t4_no_ovf", a_ovf, 0);

    // 5: both banks full when the next row lands -> dropped
    do_reset();
    for (int r = 0; r < 3*D + 1; r++) begin
      send_seq(r);
      if (r + 1 == 96) chk("t5_no_ovf_yet", a_ovf, 0);
      if (r + 1 == 97) chk("t5_ovf_set", a_ovf, 1);
    end
    idle(40);
    chk("t5_ovf_sticky", a_ovf, 1);
    chk("t5_drained", a_v, 0);

    // 6: reset in the middle of a burst
    do_reset();
    for (int r = 0; r < D; r++) send_seq(r);
    idle(11);
    chk("t6_row10_valid", a_v, 1);
    chk("t6_row10_re0", sv12(a_re[0]), 160);
    #2 rstn = 1'b0;
    #1;
    chk("t6_abort_valid", a_v, 0);
    chk("t6_abort_dout", sv12(a_re[0]), 0);
    chk("t6_abort_flags", {a_fd, a_ovf, a_sat, b_v}, 0);
    idle(3);
    rstn = 1'b1;
    for (int r = 0; r < D; r++) send_seq(r);
    idle(1);
    chk("t6_fresh_valid", a_v, 1);
    chk("t6_fresh_re3", sv12(a_re[3]), 3);
    idle(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
